// File: rtl/serial_sum_collector.sv
// ============================================================================
//  Module      : serial_sum_collector
//  Description : Collects LSB-first serial sum bits and the final carry into
//                a (reglength+1)-bit word, with a valid/ready result handshake
//                and framing-error detection.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sum_collector #(
   parameter int reglength = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 bit_valid,
   input  logic                 bit_first,
   input  logic                 sum_bit,
   input  logic                 carry_bit,
   output logic                 in_ready,
   output logic [reglength:0]   summa,
   output logic                 summa_valid,
   input  logic                 summa_ready,
   output logic                 frame_err
);

   localparam int CW = (reglength > 1) ? $clog2(reglength) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [reglength:0]   asm_q, asm_d;
   logic [reglength:0]   summa_q, summa_d;
   logic                 frame_err_q, frame_err_d;
   logic                 accept;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      asm_d       = asm_q;
      summa_d     = summa_q;
      frame_err_d = 1'b0;
      accept      = bit_valid && (state_q != ST_HOLD);

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (bit_first) begin
                  asm_d    = '0;
                  asm_d[0] = sum_bit;
                  if (reglength == 1) begin
                     // A one-bit word is complete on its first (and only) bit
                     asm_d[reglength] = carry_bit;
                     summa_d          = asm_d;
                     cnt_d            = '0;
                     state_d          = ST_HOLD;
                  end else begin
                     cnt_d   = CW'(1);
                     state_d = ST_COLLECT;
                  end
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end

         ST_COLLECT: begin
            if (accept) begin
               if (bit_first) begin
                  // Resync: drop the partial word and restart on this bit
                  frame_err_d = 1'b1;
                  asm_d       = '0;
                  asm_d[0]    = sum_bit;
                  cnt_d       = CW'(1);
               end else begin
                  asm_d[cnt_q] = sum_bit;
                  if (cnt_q == CW'(reglength - 1)) begin
                     asm_d[reglength] = carry_bit;
                     summa_d          = asm_d;
                     cnt_d            = '0;
                     state_d          = ST_HOLD;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
         end

         ST_HOLD: begin
            if (summa_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         asm_q       <= '0;
         summa_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         asm_q       <= asm_d;
         summa_q     <= summa_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign in_ready    = (state_q != ST_HOLD);
   assign summa_valid = (state_q == ST_HOLD);
   assign summa       = summa_q;
   assign frame_err   = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_sum_collector.sv
// ============================================================================
//  Module      : tb_serial_sum_collector
//  Description : Directed and randomized bench for serial_sum_collector
//                (reglength=3 and reglength=1 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_sum_collector;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       bit_valid, bit_first, sum_bit, carry_bit;
   logic       in_ready, summa_valid, summa_ready, frame_err;
   logic [3:0] summa;

   logic       b1_valid, b1_first, b1_sum, b1_carry;
   logic       b1_in_ready, b1_summa_valid, b1_summa_ready, b1_frame_err;
   logic [1:0] b1_summa;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_sum_collector #(.reglength(3)) u_dut3 (
      .clk         (clk),
      .rst_n       (rst_n),
      .bit_valid   (bit_valid),
      .bit_first   (bit_first),
      .sum_bit     (sum_bit),
      .carry_bit   (carry_bit),
      .in_ready    (in_ready),
      .summa       (summa),
      .summa_valid (summa_valid),
      .summa_ready (summa_ready),
      .frame_err   (frame_err)
   );

   serial_sum_collector #(.reglength(1)) u_dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .bit_valid   (b1_valid),
      .bit_first   (b1_first),
      .sum_bit     (b1_sum),
      .carry_bit   (b1_carry),
      .in_ready    (b1_in_ready),
      .summa       (b1_summa),
      .summa_valid (b1_summa_valid),
      .summa_ready (b1_summa_ready),
      .frame_err   (b1_frame_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic f, input logic s, input logic c);
      bit_valid = 1'b1;
      bit_first = f;
      sum_bit   = s;
      carry_bit = c;
      step();
      bit_valid = 1'b0;
      bit_first = 1'b0;
      sum_bit   = 1'b0;
      carry_bit = 1'b0;
   endtask

   task automatic handshake(input string tag);
      summa_ready = 1'b1;
      step();
      summa_ready = 1'b0;
      chk({tag, "_hs_valid"}, summa_valid, 1'b0);
      chk({tag, "_hs_ready"}, in_ready, 1'b1);
   endtask

   // Reference: the word is simply a+b; each position carries its sum bit and
   // the carry out of the low (i+1) bits of the addition.
   task automatic send_word(input int unsigned a, input int unsigned b,
                            input int unsigned gap_max, input string tag);
      int unsigned total;
      total = (a & 7) + (b & 7);
      for (int i = 0; i < 3; i++) begin
         int unsigned m;
         logic s, c;
         m = (1 << (i + 1)) - 1;
         s = total[i];
         c = ((((a & m) + (b & m)) >> (i + 1)) & 1) != 0;
         drive(i == 0, s, c);
         if (i < 2) begin
            chk({tag, "_midvalid"}, summa_valid, 1'b0);
            repeat ($urandom_range(gap_max, 0)) step();
         end
      end
      chk({tag, "_valid"}, summa_valid, 1'b1);
      chk({tag, "_summa"}, summa, total[3:0]);
      chk({tag, "_inrdy"}, in_ready, 1'b0);
   endtask

   initial begin
      logic [3:0] held;
      rst_n = 1'b0;
      bit_valid = 0; bit_first = 0; sum_bit = 0; carry_bit = 0; summa_ready = 0;
      b1_valid = 0; b1_first = 0; b1_sum = 0; b1_carry = 0; b1_summa_ready = 0;
      step();
      rst_n = 1'b1;
      chk("rst_summa", summa, 4'd0);
      chk("rst_valid", summa_valid, 1'b0);
      chk("rst_inrdy", in_ready, 1'b1);
      chk("rst_ferr", frame_err, 1'b0);
      chk("rst1_summa", b1_summa, 2'd0);
      chk("rst1_inrdy", b1_in_ready, 1'b1);

      // 5+3
      drive(1, 0, 1);
      drive(0, 0, 1);
      chk("t1_notyet", summa_valid, 1'b0);
      drive(0, 0, 1);
      chk("t1_valid", summa_valid, 1'b1);
      chk("t1_summa", summa, 4'b1000);
      handshake("t1");

      // 2+1 with a gap, then held result
      drive(1, 1, 0);
      step(); step();
      chk("t2_gap_valid", summa_valid, 1'b0);
      drive(0, 1, 0);
      drive(0, 0, 0);
      chk("t2_summa", summa, 4'b0011);
      for (int k = 0; k < 4; k++) begin
         bit_valid = 1'b1;
         bit_first = 1'b1;
         sum_bit   = 1'b1;
         step();
         chk("t2_hold_summa", summa, 4'b0011);
         chk("t2_hold_valid", summa_valid, 1'b1);
         chk("t2_hold_inrdy", in_ready, 1'b0);
      end
      bit_valid = 1'b0; bit_first = 1'b0; sum_bit = 1'b0;
      handshake("t2");

      // Stray bit in IDLE, then 7+7
      drive(0, 1, 1);
      chk("t3_ferr", frame_err, 1'b1);
      chk("t3_valid", summa_valid, 1'b0);
      chk("t3_inrdy", in_ready, 1'b1);
      step();
      chk("t3_ferr_end", frame_err, 1'b0);
      drive(1, 0, 1);
      chk("t3_noerr", frame_err, 1'b0);
      drive(0, 1, 1);
      drive(0, 1, 1);
      chk("t3_summa", summa, 4'b1110);
      chk("t3_valid2", summa_valid, 1'b1);
      handshake("t3");

      // Resync on early bit_first
      drive(1, 0, 0);
      drive(0, 0, 0);
      drive(1, 1, 0);
      chk("t4_ferr", frame_err, 1'b1);
      chk("t4_valid", summa_valid, 1'b0);
      drive(0, 0, 0);
      chk("t4_ferr_end", frame_err, 1'b0);
      drive(0, 1, 1);
      chk("t4_valid2", summa_valid, 1'b1);
      chk("t4_summa", summa, 4'b1101);
      handshake("t4");

      // Reset mid-word
      drive(1, 1, 1);
      drive(0, 1, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("t5_summa", summa, 4'd0);
      chk("t5_valid", summa_valid, 1'b0);
      chk("t5_inrdy", in_ready, 1'b1);
      send_word(3, 6, 0, "t5a");
      handshake("t5a");

      // Reset during HOLD
      send_word(5, 6, 0, "t5b");
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("t5b_summa", summa, 4'd0);
      chk("t5b_valid", summa_valid, 1'b0);
      chk("t5b_inrdy", in_ready, 1'b1);
      send_word(4, 4, 0, "t5c");
      handshake("t5c");

      // reglength=1
      b1_valid = 1'b1; b1_first = 1'b1; b1_sum = 1'b1; b1_carry = 1'b1;
      step();
      b1_valid = 1'b0; b1_first = 1'b0; b1_sum = 1'b0; b1_carry = 1'b0;
      chk("t6_summa", b1_summa, 2'b11);
      chk("t6_valid", b1_summa_valid, 1'b1);
      chk("t6_inrdy", b1_in_ready, 1'b0);
      b1_summa_ready = 1'b1;
      step();
      b1_summa_ready = 1'b0;
      chk("t6_hs_valid", b1_summa_valid, 1'b0);

      // Randomized words with gaps and consumer back-pressure
      for (int w = 0; w < 20; w++) begin
         send_word($urandom_range(7, 0), $urandom_range(7, 0), 2, "rnd");
         held = summa;
         repeat ($urandom_range(3, 0)) begin
            step();
            chk("rnd_stable", summa, held);
            chk("rnd_hold_valid", summa_valid, 1'b1);
         end
         chk("rnd_ferr", frame_err, 1'b0);
         handshake("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
